// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard requests in, per-stage write-enable/flush controls out.
interface pipe_hazard_ctrl_if;
    logic        lw_stall;
    logic        branch_taken;
    logic        jump_id;
    logic        md_req;
    logic        mem_wait;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_write;
    logic        id_ex_flush;
    logic        ex_mem_write;
    logic        ex_mem_flush;
    logic        md_busy;
    logic [15:0] stall_cnt;
    modport master (
        output lw_stall, branch_taken, jump_id, md_req, mem_wait,
        input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               ex_mem_write, ex_mem_flush, md_busy, stall_cnt
    );
    modport slave (
        input  lw_stall, branch_taken, jump_id, md_req, mem_wait,
        output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               ex_mem_write, ex_mem_flush, md_busy, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: prioritised stall/flush scheduler with mul/div sequencing
// and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 6
) (
    input logic               clk,
    input logic               rst_n,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic {RUN, MD_WAIT} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      stall_cnt_q, stall_cnt_d;
    logic             md_freeze, md_release;
    logic             pc_w, if_id_w, if_id_f, id_ex_w, id_ex_f, ex_mem_w, ex_mem_f, busy;
    always_comb begin
        md_freeze  = (state_q == RUN && hz.md_req) || (state_q == MD_WAIT && cnt_q != '0);
        md_release = state_q == MD_WAIT && cnt_q == '0;
        busy       = state_q == MD_WAIT || (hz.md_req && !hz.mem_wait);
        pc_w       = 1'b1;
        if_id_w    = 1'b1;
        id_ex_w    = 1'b1;
        ex_mem_w   = 1'b1;
        if_id_f    = 1'b0;
        id_ex_f    = 1'b0;
        ex_mem_f   = 1'b0;
        if (hz.mem_wait) begin
            pc_w     = 1'b0;
            if_id_w  = 1'b0;
            id_ex_w  = 1'b0;
            ex_mem_w = 1'b0;
        end else if (md_freeze) begin
            pc_w     = 1'b0;
            if_id_w  = 1'b0;
            id_ex_w  = 1'b0;
            ex_mem_f = 1'b1;
        end else if (md_release) begin
            pc_w = 1'b1;
        end else if (hz.branch_taken) begin
            if_id_f = 1'b1;
            id_ex_f = 1'b1;
        end else if (hz.lw_stall) begin
            pc_w    = 1'b0;
            if_id_w = 1'b0;
            id_ex_f = 1'b1;
        end else if (hz.jump_id) begin
            if_id_f = 1'b1;
        end
    end
    // the counter keeps draining during a memory wait; only the release waits for it
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_cnt_d = (!pc_w && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
        if (state_q == RUN) begin
            if (hz.md_req && !hz.mem_wait) begin
                state_d = MD_WAIT;
                cnt_d   = CNT_W'(MD_LATENCY - 2);
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (!hz.mem_wait) begin
            state_d = RUN;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
    assign hz.pc_write     = rst_n & pc_w;
    assign hz.if_id_write  = rst_n & if_id_w;
    assign hz.if_id_flush  = rst_n & if_id_f;
    assign hz.id_ex_write  = rst_n & id_ex_w;
    assign hz.id_ex_flush  = rst_n & id_ex_f;
    assign hz.ex_mem_write = rst_n & ex_mem_w;
    assign hz.ex_mem_flush = rst_n & ex_mem_f;
    assign hz.md_busy      = rst_n & busy;
    assign hz.stall_cnt    = stall_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenario tasks for pipe_hazard_ctrl (MD_LATENCY=4).
module tb_pipe_hazard_ctrl;
    // control vector order: pc_w, if_id_w, if_id_f, id_ex_w, id_ex_f, ex_mem_w, ex_mem_f, md_busy
    localparam logic [7:0] C_RST = 8'b0000_0000;
    localparam logic [7:0] C_DEF = 8'b1101_0100;
    localparam logic [7:0] C_LW  = 8'b0001_1100;
    localparam logic [7:0] C_BR  = 8'b1111_1100;
    localparam logic [7:0] C_JMP = 8'b1111_0100;
    localparam logic [7:0] C_MDF = 8'b0000_0111;
    localparam logic [7:0] C_REL = 8'b1101_0101;
    localparam logic [7:0] C_MWB = 8'b0000_0001;
    localparam logic [7:0] C_MW  = 8'b0000_0000;
    logic        clk;
    logic        rst_n;
    logic [7:0]  ctl;
    logic [15:0] exp_cnt;
    int          vectors;
    int          miscompares;
    pipe_hazard_ctrl_if hz();
    pipe_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(3)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));
    assign ctl = {hz.pc_write, hz.if_id_write, hz.if_id_flush, hz.id_ex_write,
                  hz.id_ex_flush, hz.ex_mem_write, hz.ex_mem_flush, hz.md_busy};
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic clear_in();
        hz.lw_stall = 0; hz.branch_taken = 0; hz.jump_id = 0; hz.md_req = 0; hz.mem_wait = 0;
    endtask
    task automatic test_reset();
        rst_n = 0;
        clear_in();
        #2;
        vectors++;
        if (ctl !== C_RST) begin miscompares++; $display("FAIL reset_ctl got %b want %b", ctl, C_RST); end
        vectors++;
        if (hz.stall_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_cnt got %0d want 0", hz.stall_cnt); end
        @(negedge clk);
        rst_n = 1;
        tick();
        #1;
        vectors++;
        if (ctl !== C_DEF) begin miscompares++; $display("FAIL idle_ctl got %b want %b", ctl, C_DEF); end
        vectors++;
        if (hz.stall_cnt !== 16'd0) begin miscompares++; $display("FAIL idle_cnt got %0d want 0", hz.stall_cnt); end
        exp_cnt = 0;
    endtask
    task automatic test_lw_stall();
        tick();
        hz.lw_stall = 1;
        #1;
        vectors++;
        if (ctl !== C_LW) begin miscompares++; $display("FAIL lw_ctl got %b want %b", ctl, C_LW); end
        tick(); exp_cnt++;
        hz.lw_stall = 0;
        #1;
        vectors++;
        if (ctl !== C_DEF) begin miscompares++; $display("FAIL lw_after_ctl got %b want %b", ctl, C_DEF); end
        vectors++;
        if (hz.stall_cnt !== exp_cnt) begin miscompares++; $display("FAIL lw_cnt got %0d want %0d", hz.stall_cnt, exp_cnt); end
    endtask
    task automatic test_branch_over_lw();
        tick();
        hz.lw_stall = 1; hz.branch_taken = 1;
        #1;
        vectors++;
        if (ctl !== C_BR) begin miscompares++; $display("FAIL br_lw_ctl got %b want %b", ctl, C_BR); end
        tick();
        clear_in();
        #1;
        vectors++;
        if (hz.stall_cnt !== exp_cnt) begin miscompares++; $display("FAIL br_lw_cnt got %0d want %0d", hz.stall_cnt, exp_cnt); end
    endtask
    task automatic test_jump();
        tick();
        hz.jump_id = 1;
        #1;
        vectors++;
        if (ctl !== C_JMP) begin miscompares++; $display("FAIL jump_ctl got %b want %b", ctl, C_JMP); end
        tick();
        hz.lw_stall = 1;
        #1;
        vectors++;
        if (ctl !== C_LW) begin miscompares++; $display("FAIL jump_lw_ctl got %b want %b", ctl, C_LW); end
        tick(); exp_cnt++;
        hz.lw_stall = 0;
        #1;
        vectors++;
        if (ctl !== C_JMP) begin miscompares++; $display("FAIL jump_retry_ctl got %b want %b", ctl, C_JMP); end
        tick();
        hz.jump_id = 0; hz.branch_taken = 1; hz.mem_wait = 1;
        #1;
        vectors++;
        if (ctl !== C_MW) begin miscompares++; $display("FAIL memwait_run_ctl got %b want %b", ctl, C_MW); end
        tick(); exp_cnt++;
        clear_in();
        #1;
        vectors++;
        if (hz.stall_cnt !== exp_cnt) begin miscompares++; $display("FAIL jump_cnt got %0d want %0d", hz.stall_cnt, exp_cnt); end
    endtask
    task automatic test_md();
        exp_cnt = hz.stall_cnt === exp_cnt ? exp_cnt : exp_cnt;
        tick();
        hz.md_req = 1;
        #1;
        vectors++;
        if (ctl !== C_MDF) begin miscompares++; $display("FAIL md_c1_ctl got %b want %b", ctl, C_MDF); end
        tick(); exp_cnt++;
        hz.branch_taken = 1; hz.lw_stall = 1;
        #1;
        vectors++;
        if (ctl !== C_MDF) begin miscompares++; $display("FAIL md_c2_ctl got %b want %b", ctl, C_MDF); end
        tick(); exp_cnt++;
        hz.branch_taken = 0; hz.lw_stall = 0;
        #1;
        vectors++;
        if (ctl !== C_MDF) begin miscompares++; $display("FAIL md_c3_ctl got %b want %b", ctl, C_MDF); end
        tick(); exp_cnt++;
        #1;
        vectors++;
        if (ctl !== C_REL) begin miscompares++; $display("FAIL md_release_ctl got %b want %b", ctl, C_REL); end
        tick();
        hz.md_req = 0;
        #1;
        vectors++;
        if (ctl !== C_DEF) begin miscompares++; $display("FAIL md_run_ctl got %b want %b", ctl, C_DEF); end
        vectors++;
        if (hz.stall_cnt !== exp_cnt) begin miscompares++; $display("FAIL md_cnt got %0d want %0d", hz.stall_cnt, exp_cnt); end
    endtask
    task automatic test_md_mem_wait();
        tick();
        hz.md_req = 1;
        tick(); exp_cnt++;
        tick(); exp_cnt++;
        hz.mem_wait = 1;
        #1;
        vectors++;
        if (ctl !== C_MWB) begin miscompares++; $display("FAIL mdmw_c1_ctl got %b want %b", ctl, C_MWB); end
        tick(); exp_cnt++;
        #1;
        vectors++;
        if (ctl !== C_MWB) begin miscompares++; $display("FAIL mdmw_c2_ctl got %b want %b", ctl, C_MWB); end
        tick(); exp_cnt++;
        hz.mem_wait = 0;
        #1;
        vectors++;
        if (ctl !== C_REL) begin miscompares++; $display("FAIL mdmw_release_ctl got %b want %b", ctl, C_REL); end
        tick();
        hz.md_req = 0;
        #1;
        vectors++;
        if (ctl !== C_DEF) begin miscompares++; $display("FAIL mdmw_run_ctl got %b want %b", ctl, C_DEF); end
        vectors++;
        if (hz.stall_cnt !== exp_cnt) begin miscompares++; $display("FAIL mdmw_cnt got %0d want %0d", hz.stall_cnt, exp_cnt); end
    endtask
    task automatic test_reset_mid_md();
        tick();
        hz.md_req = 1;
        tick();
        tick();
        rst_n = 0;
        #1;
        vectors++;
        if (ctl !== C_RST) begin miscompares++; $display("FAIL midrst_ctl got %b want %b", ctl, C_RST); end
        vectors++;
        if (hz.stall_cnt !== 16'd0) begin miscompares++; $display("FAIL midrst_cnt got %0d want 0", hz.stall_cnt); end
        hz.md_req = 0;
        #1;
        rst_n = 1;
        #1;
        vectors++;
        if (ctl !== C_DEF) begin miscompares++; $display("FAIL midrst_run_ctl got %b want %b", ctl, C_DEF); end
        tick();
        vectors++;
        if (hz.stall_cnt !== 16'd0) begin miscompares++; $display("FAIL midrst_after_cnt got %0d want 0", hz.stall_cnt); end
    endtask
    task automatic test_saturation();
        hz.lw_stall = 1;
        repeat (70000) tick();
        vectors++;
        if (hz.stall_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL sat_cnt got %h want ffff", hz.stall_cnt); end
        tick();
        tick();
        vectors++;
        if (hz.stall_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hold_cnt got %h want ffff", hz.stall_cnt); end
        hz.lw_stall = 0;
    endtask
    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_cnt     = 0;
        test_reset();
        test_lw_stall();
        test_branch_over_lw();
        test_jump();
        test_md();
        test_md_mem_wait();
        test_reset_mid_md();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
